// File: rtl/uart_hex_parser.sv
// uart_hex_parser: turns a stream of ASCII hex digits from the UART RX FIFO
// into binary values, one per CR/LF-terminated line, with a valid/ack
// handshake towards the consumer and an error pulse for malformed lines.
module uart_hex_parser #(
  parameter int DIGITS = 4,
  localparam int W = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_ready,
  input  logic [7:0]   rx_byte,
  output logic         rx_read,
  output logic [W-1:0] val,
  output logic         val_valid,
  input  logic         val_ack,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [W-1:0]  val_next;
  logic          val_valid_next;
  logic          err_next;
  logic [1:0]    err_code_next;

  logic          is_digit;
  logic          is_term;
  logic [3:0]    nibble;

  // While a result waits for its ack the parser stops reading, so the FIFO
  // buffers the next line instead of the parser dropping it.
  assign rx_read = rx_ready && !rst && (state != HOLD);

  // Classify the FIFO head byte as hex digit, line terminator or illegal.
  always_comb begin
    is_digit = 1'b0;
    is_term  = 1'b0;
    nibble   = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 lands on 10.
      is_digit = 1'b1;
      nibble   = rx_byte[3:0] + 4'd9;
    end else if (rx_byte == 8'h0D || rx_byte == 8'h0A) begin
      is_term = 1'b1;
    end
  end

  // Next-state and datapath decisions for each consumed byte or ack.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    count_next     = count;
    val_next       = val;
    val_valid_next = val_valid;
    err_next       = 1'b0;
    err_code_next  = err_code;
    case (state)
      ACCUM: begin
        if (rx_read) begin
          if (is_digit) begin
            if (count < CW'(DIGITS)) begin
              acc_next   = (acc << 4) | W'(nibble);
              count_next = count + CW'(1);
            end else begin
              err_next      = 1'b1;
              err_code_next = 2'd2;
              state_next    = DISCARD;
            end
          end else if (is_term) begin
            // An empty line (including the LF of a CRLF pair) is skipped.
            if (count != '0) begin
              val_next       = acc;
              val_valid_next = 1'b1;
              acc_next       = '0;
              count_next     = '0;
              state_next     = HOLD;
            end
          end else begin
            err_next      = 1'b1;
            err_code_next = 2'd1;
            state_next    = DISCARD;
          end
        end
      end
      DISCARD: begin
        // Only one error pulse per bad line; everything up to its end is dropped.
        if (rx_read && is_term) begin
          acc_next   = '0;
          count_next = '0;
          state_next = ACCUM;
        end
      end
      HOLD: begin
        if (val_ack) begin
          val_valid_next = 1'b0;
          state_next     = ACCUM;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // State register; reset abandons any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Accumulator, result and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      val       <= '0;
      val_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      acc       <= acc_next;
      count     <= count_next;
      val       <= val_next;
      val_valid <= val_valid_next;
      err       <= err_next;
      err_code  <= err_code_next;
    end
  end

endmodule

// File: tb/tb_uart_hex_parser.sv
// tb_uart_hex_parser: drives ASCII lines through a model RX FIFO and
// scoreboards the parsed values and error codes against expectations.
module tb_uart_hex_parser;

  localparam int W = 16;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         rx_ready  = 1'b0;
  logic [7:0]   rx_byte   = 8'h00;
  logic         rx_read;
  logic [W-1:0] val;
  logic         val_valid;
  logic         val_ack   = 1'b1;
  logic         err;
  logic [1:0]   err_code;

  logic [7:0]   fifo[$];
  int           rd_ptr = 0;
  logic         rd_n = 1'b0;
  logic         prev_valid = 1'b0;
  int           rd_cycles = 0;
  int           valid_cycles = 0;
  int           err_pulses = 0;

  logic [W-1:0] exp_val_q[$];
  logic [W-1:0] obs_val_q[$];
  logic [1:0]   exp_err_q[$];
  logic [1:0]   obs_err_q[$];
  int           obs_vi = 0;
  int           obs_ei = 0;

  int           vectors = 0;
  int           miscompares = 0;

  uart_hex_parser #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_ready  (rx_ready),
    .rx_byte   (rx_byte),
    .rx_read   (rx_read),
    .val       (val),
    .val_valid (val_valid),
    .val_ack   (val_ack),
    .err       (err),
    .err_code  (err_code)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // RX FIFO model: pops the head after an edge on which rx_read was high.
  always @(posedge clk) begin
    #1;
    if (rd_n) rd_ptr = rd_ptr + 1;
    rx_ready = (rd_ptr < fifo.size());
    rx_byte  = rx_ready ? fifo[rd_ptr] : 8'h00;
  end

  // Monitor: records handshake activity and captures results and errors.
  always @(negedge clk) begin
    rd_n = rx_read;
    if (rx_read) rd_cycles++;
    if (val_valid) valid_cycles++;
    if (val_valid && !prev_valid) obs_val_q.push_back(val);
    prev_valid = val_valid;
    if (err) begin
      err_pulses++;
      obs_err_q.push_back(err_code);
    end
  end

  // Hard stop in case something deadlocks outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!rx_ready && rd_ptr == fifo.size() && !val_valid) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (val !== '0) begin miscompares++; $display("[TB] FAIL reset_val actual=%h required=0000", val); end
    vectors++; if (val_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_val_valid actual=%b required=0", val_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err actual=%b required=0", err); end
    vectors++; if (err_code !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_err_code actual=%0d required=0", err_code); end
    vectors++; if (rx_read !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_read actual=%b required=0", rx_read); end
    #10 rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int r0, v0, e0;
    bit ok;
    logic [W-1:0] e;
    r0 = rd_cycles; v0 = valid_cycles; e0 = err_pulses;
    push_str("1A2F"); push_byte(8'h0D);
    exp_val_q.push_back(16'h1A2F);
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL b2b_idle actual=busy required=idle"); end
    vectors++; if (rd_cycles - r0 != 5) begin miscompares++; $display("[TB] FAIL b2b_rx_read_cycles actual=%0d required=5", rd_cycles - r0); end
    vectors++; if (valid_cycles - v0 != 1) begin miscompares++; $display("[TB] FAIL b2b_valid_cycles actual=%0d required=1", valid_cycles - v0); end
    vectors++; if (err_pulses - e0 != 0) begin miscompares++; $display("[TB] FAIL b2b_err_pulses actual=%0d required=0", err_pulses - e0); end
    while (exp_val_q.size() > 0) begin
      e = exp_val_q.pop_front(); vectors++;
      if (obs_vi >= obs_val_q.size()) begin miscompares++; $display("[TB] FAIL b2b_val actual=none required=%h", e); end
      else begin if (obs_val_q[obs_vi] !== e) begin miscompares++; $display("[TB] FAIL b2b_val actual=%h required=%h", obs_val_q[obs_vi], e); end obs_vi++; end
    end
    vectors++; if (obs_vi != obs_val_q.size()) begin miscompares++; $display("[TB] FAIL b2b_extra_val actual=%0d required=0", obs_val_q.size() - obs_vi); obs_vi = obs_val_q.size(); end
  endtask

  task automatic test_crlf;
    int v0, e0;
    bit ok;
    logic [W-1:0] e;
    v0 = valid_cycles; e0 = err_pulses;
    push_str("beef"); push_byte(8'h0D); push_byte(8'h0A);
    push_str("7"); push_byte(8'h0A);
    exp_val_q.push_back(16'hBEEF);
    exp_val_q.push_back(16'h0007);
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL crlf_idle actual=busy required=idle"); end
    vectors++; if (valid_cycles - v0 != 2) begin miscompares++; $display("[TB] FAIL crlf_valid_cycles actual=%0d required=2", valid_cycles - v0); end
    vectors++; if (err_pulses - e0 != 0) begin miscompares++; $display("[TB] FAIL crlf_err_pulses actual=%0d required=0", err_pulses - e0); end
    while (exp_val_q.size() > 0) begin
      e = exp_val_q.pop_front(); vectors++;
      if (obs_vi >= obs_val_q.size()) begin miscompares++; $display("[TB] FAIL crlf_val actual=none required=%h", e); end
      else begin if (obs_val_q[obs_vi] !== e) begin miscompares++; $display("[TB] FAIL crlf_val actual=%h required=%h", obs_val_q[obs_vi], e); end obs_vi++; end
    end
    vectors++; if (obs_vi != obs_val_q.size()) begin miscompares++; $display("[TB] FAIL crlf_extra_val actual=%0d required=0", obs_val_q.size() - obs_vi); obs_vi = obs_val_q.size(); end
  endtask

  task automatic test_illegal;
    int e0;
    bit ok;
    logic [W-1:0] e;
    logic [1:0] c;
    e0 = err_pulses;
    push_str("12G4"); push_byte(8'h0D);
    push_str("C3"); push_byte(8'h0D);
    exp_err_q.push_back(2'd1);
    exp_val_q.push_back(16'h00C3);
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL illegal_idle actual=busy required=idle"); end
    vectors++; if (err_pulses - e0 != 1) begin miscompares++; $display("[TB] FAIL illegal_err_pulses actual=%0d required=1", err_pulses - e0); end
    vectors++; if (err_code !== 2'd1) begin miscompares++; $display("[TB] FAIL illegal_err_code_hold actual=%0d required=1", err_code); end
    while (exp_err_q.size() > 0) begin
      c = exp_err_q.pop_front(); vectors++;
      if (obs_ei >= obs_err_q.size()) begin miscompares++; $display("[TB] FAIL illegal_err actual=none required=%0d", c); end
      else begin if (obs_err_q[obs_ei] !== c) begin miscompares++; $display("[TB] FAIL illegal_err actual=%0d required=%0d", obs_err_q[obs_ei], c); end obs_ei++; end
    end
    while (exp_val_q.size() > 0) begin
      e = exp_val_q.pop_front(); vectors++;
      if (obs_vi >= obs_val_q.size()) begin miscompares++; $display("[TB] FAIL illegal_val actual=none required=%h", e); end
      else begin if (obs_val_q[obs_vi] !== e) begin miscompares++; $display("[TB] FAIL illegal_val actual=%h required=%h", obs_val_q[obs_vi], e); end obs_vi++; end
    end
    vectors++; if (obs_vi != obs_val_q.size()) begin miscompares++; $display("[TB] FAIL illegal_extra_val actual=%0d required=0", obs_val_q.size() - obs_vi); obs_vi = obs_val_q.size(); end
  endtask

  task automatic test_overflow;
    int e0;
    bit ok;
    logic [W-1:0] e;
    logic [1:0] c;
    e0 = err_pulses;
    push_str("12345"); push_byte(8'h0D);
    push_str("9"); push_byte(8'h0D);
    exp_err_q.push_back(2'd2);
    exp_val_q.push_back(16'h0009);
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL overflow_idle actual=busy required=idle"); end
    vectors++; if (err_pulses - e0 != 1) begin miscompares++; $display("[TB] FAIL overflow_err_pulses actual=%0d required=1", err_pulses - e0); end
    while (exp_err_q.size() > 0) begin
      c = exp_err_q.pop_front(); vectors++;
      if (obs_ei >= obs_err_q.size()) begin miscompares++; $display("[TB] FAIL overflow_err actual=none required=%0d", c); end
      else begin if (obs_err_q[obs_ei] !== c) begin miscompares++; $display("[TB] FAIL overflow_err actual=%0d required=%0d", obs_err_q[obs_ei], c); end obs_ei++; end
    end
    while (exp_val_q.size() > 0) begin
      e = exp_val_q.pop_front(); vectors++;
      if (obs_vi >= obs_val_q.size()) begin miscompares++; $display("[TB] FAIL overflow_val actual=none required=%h", e); end
      else begin if (obs_val_q[obs_vi] !== e) begin miscompares++; $display("[TB] FAIL overflow_val actual=%h required=%h", obs_val_q[obs_vi], e); end obs_vi++; end
    end
    vectors++; if (obs_vi != obs_val_q.size()) begin miscompares++; $display("[TB] FAIL overflow_extra_val actual=%0d required=0", obs_val_q.size() - obs_vi); obs_vi = obs_val_q.size(); end
  endtask

  task automatic test_hold;
    bit ok;
    bit seen;
    logic [W-1:0] e;
    val_ack = 1'b0;
    push_str("AB"); push_byte(8'h0D);
    push_str("5"); push_byte(8'h0D);
    exp_val_q.push_back(16'h00AB);
    exp_val_q.push_back(16'h0005);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (val_valid) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL hold_valid_timeout actual=0 required=1"); end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (rx_read !== 1'b0 || val !== 16'h00AB || val_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL hold_stable cycle=%0d actual rx_read=%b val=%h val_valid=%b required rx_read=0 val=00ab val_valid=1", i, rx_read, val, val_valid);
      end
      if (i < 19) @(negedge clk);
    end
    val_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (rx_read !== 1'b1 || val_valid !== 1'b0 || val !== 16'h00AB) begin
      miscompares++;
      $display("[TB] FAIL hold_release actual rx_read=%b val_valid=%b val=%h required rx_read=1 val_valid=0 val=00ab", rx_read, val_valid, val);
    end
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL hold_idle actual=busy required=idle"); end
    while (exp_val_q.size() > 0) begin
      e = exp_val_q.pop_front(); vectors++;
      if (obs_vi >= obs_val_q.size()) begin miscompares++; $display("[TB] FAIL hold_val actual=none required=%h", e); end
      else begin if (obs_val_q[obs_vi] !== e) begin miscompares++; $display("[TB] FAIL hold_val actual=%h required=%h", obs_val_q[obs_vi], e); end obs_vi++; end
    end
    vectors++; if (obs_vi != obs_val_q.size()) begin miscompares++; $display("[TB] FAIL hold_extra_val actual=%0d required=0", obs_val_q.size() - obs_vi); obs_vi = obs_val_q.size(); end
  endtask

  task automatic test_reset_midline;
    bit ok;
    bit drained;
    logic [W-1:0] e;
    push_str("AB");
    drained = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_ptr == fifo.size() && !rx_ready) begin drained = 1'b1; break; end
    end
    vectors++; if (!drained) begin miscompares++; $display("[TB] FAIL midline_drain actual=busy required=drained"); end
    @(posedge clk);
    #2 rst = 1'b1;
    #2;
    vectors++; if (val !== '0) begin miscompares++; $display("[TB] FAIL midline_val actual=%h required=0000", val); end
    vectors++; if (val_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midline_val_valid actual=%b required=0", val_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL midline_err actual=%b required=0", err); end
    vectors++; if (err_code !== 2'd0) begin miscompares++; $display("[TB] FAIL midline_err_code actual=%0d required=0", err_code); end
    push_str("C"); push_byte(8'h0D);
    exp_val_q.push_back(16'h000C);
    @(posedge clk);
    @(posedge clk);
    #3;
    vectors++; if (rx_read !== 1'b0) begin miscompares++; $display("[TB] FAIL midline_rx_read_in_reset actual=%b required=0", rx_read); end
    rst = 1'b0;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL midline_idle actual=busy required=idle"); end
    while (exp_val_q.size() > 0) begin
      e = exp_val_q.pop_front(); vectors++;
      if (obs_vi >= obs_val_q.size()) begin miscompares++; $display("[TB] FAIL midline_val_result actual=none required=%h", e); end
      else begin if (obs_val_q[obs_vi] !== e) begin miscompares++; $display("[TB] FAIL midline_val_result actual=%h required=%h", obs_val_q[obs_vi], e); end obs_vi++; end
    end
    vectors++; if (obs_vi != obs_val_q.size()) begin miscompares++; $display("[TB] FAIL midline_extra_val actual=%0d required=0", obs_val_q.size() - obs_vi); obs_vi = obs_val_q.size(); end
  endtask

  // Test sequence.
  initial begin
    test_reset;
    test_back_to_back;
    test_crlf;
    test_illegal;
    test_overflow;
    test_hold;
    test_reset_midline;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
